// File: rtl/lcd_display_ctrl_pkg.sv
// Shared constants, state encodings and byte-formatting helpers for the
// HD44780 character LCD sequencer.
package lcd_display_ctrl_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_LINE1    = 8'h80;

   localparam logic [7:0] ASCII_R      = 8'h52;
   localparam logic [7:0] ASCII_SPACE  = 8'h20;
   localparam logic [7:0] ASCII_EQ     = 8'h3D;
   localparam logic [7:0] ASCII_PLUS   = 8'h2B;
   localparam logic [7:0] ASCII_MINUS  = 8'h2D;
   localparam logic [7:0] ASCII_ZERO   = 8'h30;

   localparam logic [3:0] INIT_LAST = 4'd3;
   localparam logic [3:0] LINE_LAST = 4'd12;
   localparam logic [3:0] CONV_LAST = 4'd15;

   typedef enum logic [2:0] {
      ST_PWR_WAIT = 3'd0,
      ST_INIT     = 3'd1,
      ST_IDLE     = 3'd2,
      ST_CONVERT  = 3'd3,
      ST_WRITE    = 3'd4,
      ST_CLEAR    = 3'd5,
      ST_DONE     = 3'd6
   } ctrl_state_e;

   typedef enum logic [1:0] {
      BW_IDLE  = 2'd0,
      BW_SETUP = 2'd1,
      BW_PULSE = 2'd2,
      BW_WAIT  = 2'd3
   } bw_phase_e;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_byte_t;

   // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
   function automatic logic [19:0] dabble_add3(input logic [19:0] bcd);
      logic [19:0] res;
      res = bcd;
      for (int i = 0; i < 5; i++) begin
         if (res[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
         else                       res[i*4 +: 4] = res[i*4 +: 4];
      end
      return res;
   endfunction

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

   function automatic lcd_byte_t init_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    return {1'b0, CMD_FUNC_SET};
         4'd1:    return {1'b0, CMD_DISP_ON};
         4'd2:    return {1'b0, CMD_ENTRY};
         default: return {1'b0, CMD_CLEAR};
      endcase
   endfunction

   // Byte idx of the line-1 write: address command, then "Rtu = sddddd".
   function automatic lcd_byte_t line_byte(input logic [3:0] idx, input logic [3:0] reg_idx,
                                           input logic neg, input logic [19:0] bcd);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = (reg_idx >= 4'd10) ? 4'd1 : 4'd0;
      units = (reg_idx >= 4'd10) ? reg_idx - 4'd10 : reg_idx;
      case (idx)
         4'd0:    return {1'b0, CMD_LINE1};
         4'd1:    return {1'b1, ASCII_R};
         4'd2:    return {1'b1, digit_char(tens)};
         4'd3:    return {1'b1, digit_char(units)};
         4'd4:    return {1'b1, ASCII_SPACE};
         4'd5:    return {1'b1, ASCII_EQ};
         4'd6:    return {1'b1, ASCII_SPACE};
         4'd7:    return {1'b1, neg ? ASCII_MINUS : ASCII_PLUS};
         4'd8:    return {1'b1, digit_char(bcd[19:16])};
         4'd9:    return {1'b1, digit_char(bcd[15:12])};
         4'd10:   return {1'b1, digit_char(bcd[11:8])};
         4'd11:   return {1'b1, digit_char(bcd[7:4])};
         4'd12:   return {1'b1, digit_char(bcd[3:0])};
         default: return {1'b1, ASCII_SPACE};
      endcase
   endfunction

endpackage

// File: rtl/lcd_display_ctrl_if.sv
// CPU-side request/acknowledge bundle of the LCD display controller.
interface lcd_display_ctrl_if;
   logic               disp_req;
   logic               disp_clr;
   logic [3:0]         disp_reg;
   logic signed [15:0] disp_value;
   logic               disp_ready;
   logic               disp_done;

   modport master (output disp_req, disp_clr, disp_reg, disp_value,
                   input  disp_ready, disp_done);
   modport slave  (input  disp_req, disp_clr, disp_reg, disp_value,
                   output disp_ready, disp_done);
endinterface

// File: rtl/lcd_display_ctrl_byte_writer.sv
// Drives one LCD byte: setup with E low, E pulse, then the post-byte wait.
// A new start on the final wait cycle chains the next byte with no gap.
module lcd_byte_writer
   import lcd_display_ctrl_pkg::*;
#(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 25,
   parameter int T_CMD   = 2_500,
   parameter int T_CLEAR = 100_000,
   parameter int CNT_W   = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_val,
   input  logic       rs,
   input  logic       long_wait,
   output logic [7:0] lcd_data_bus,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic       busy,
   output logic       byte_done
);

   bw_phase_e        phase_r, phase_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [7:0]       data_r, data_s;
   logic             rs_r, rs_s, e_r, e_s, long_r, long_s, load_s;

   assign busy      = (phase_r != BW_IDLE);
   assign byte_done = (phase_r == BW_WAIT) && (cnt_r == '0);
   assign load_s    = start && (!busy || byte_done);

   // Next phase and countdown value
   always_comb begin
      phase_s = phase_r;
      cnt_s   = cnt_r;
      case (phase_r)
         BW_IDLE: begin
            if (load_s) begin phase_s = BW_SETUP; cnt_s = CNT_W'(T_SETUP - 1); end
            else        begin phase_s = BW_IDLE;  cnt_s = cnt_r; end
         end
         BW_SETUP: begin
            if (cnt_r == '0) begin phase_s = BW_PULSE; cnt_s = CNT_W'(T_PULSE - 1); end
            else             begin cnt_s = cnt_r - CNT_W'(1); end
         end
         BW_PULSE: begin
            if (cnt_r == '0) begin
               phase_s = BW_WAIT;
               cnt_s   = long_r ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         BW_WAIT: begin
            if (cnt_r != '0) begin cnt_s = cnt_r - CNT_W'(1); end
            else if (load_s) begin phase_s = BW_SETUP; cnt_s = CNT_W'(T_SETUP - 1); end
            else             begin phase_s = BW_IDLE;  cnt_s = '0; end
         end
         default: begin phase_s = BW_IDLE; cnt_s = '0; end
      endcase
   end

   // Pin values for the next cycle; data and RS change only when a byte is loaded
   always_comb begin
      e_s = (phase_s == BW_PULSE);
      if (load_s) begin
         data_s = byte_val;
         rs_s   = rs;
         long_s = long_wait;
      end else begin
         data_s = data_r;
         rs_s   = rs_r;
         long_s = long_r;
      end
   end

   // Phase, counter and pin registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_r <= BW_IDLE;
         cnt_r   <= '0;
         data_r  <= 8'h00;
         rs_r    <= 1'b0;
         e_r     <= 1'b0;
         long_r  <= 1'b0;
      end else begin
         phase_r <= phase_s;
         cnt_r   <= cnt_s;
         data_r  <= data_s;
         rs_r    <= rs_s;
         e_r     <= e_s;
         long_r  <= long_s;
      end
   end

   assign lcd_data_bus = data_r;
   assign lcd_rs       = rs_r;
   assign lcd_e        = e_r;

endmodule

// File: rtl/lcd_display_ctrl.sv
// HD44780 sequencer: power-on init, then per CPU request either a clear or a
// formatted "Rtu = sddddd" write of one register value to line 1.
module lcd_display_ctrl
   import lcd_display_ctrl_pkg::*;
#(
   parameter int T_POWER = 750_000,
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 25,
   parameter int T_CMD   = 2_500,
   parameter int T_CLEAR = 100_000,
   parameter int CNT_W   = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   lcd_display_ctrl_if.slave    bus,
   output logic [7:0]           lcd_data_bus,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_e
);

   ctrl_state_e      state_r, state_s;
   logic [CNT_W-1:0] pwr_cnt_r;
   logic [3:0]       idx_r, conv_cnt_r, reg_r;
   logic             neg_r, ready_r, done_r, ready_s, done_s;
   logic [15:0]      bin_r, mag_s;
   logic [19:0]      bcd_r, bcd_adj_s;
   logic             accept_s, start_s, wr_go_s, wr_busy_s, wr_done_s, wr_long_s;
   lcd_byte_t        tx_s;

   assign accept_s  = ready_r && (bus.disp_req || bus.disp_clr);
   // 16-bit two's complement negate of -32768 gives 0x8000, i.e. 32768 read unsigned
   assign mag_s     = bus.disp_value[15] ? (16'd0 - bus.disp_value) : bus.disp_value;
   assign bcd_adj_s = dabble_add3(bcd_r);
   assign wr_go_s   = start_s && (!wr_busy_s || wr_done_s);

   // Next state and byte-start decisions
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      case (state_r)
         ST_PWR_WAIT: begin
            if (pwr_cnt_r == CNT_W'(T_POWER - 1)) begin state_s = ST_INIT; start_s = 1'b1; end
            else                                  begin state_s = ST_PWR_WAIT; end
         end
         ST_INIT: begin
            if (wr_done_s && (idx_r == INIT_LAST)) state_s = ST_IDLE;
            else if (wr_done_s)                   start_s = 1'b1;
            else                                  state_s = ST_INIT;
         end
         ST_IDLE, ST_DONE: begin
            if (accept_s && bus.disp_clr) begin state_s = ST_CLEAR; start_s = 1'b1; end
            else if (accept_s)            begin state_s = ST_CONVERT; end
            else                          begin state_s = ST_IDLE; end
         end
         ST_CONVERT: begin
            if (conv_cnt_r == CONV_LAST) begin state_s = ST_WRITE; start_s = 1'b1; end
            else                         begin state_s = ST_CONVERT; end
         end
         ST_WRITE: begin
            if (wr_done_s && (idx_r == LINE_LAST)) state_s = ST_DONE;
            else if (wr_done_s)                   start_s = 1'b1;
            else                                  state_s = ST_WRITE;
         end
         ST_CLEAR: begin
            if (wr_done_s) state_s = ST_DONE;
            else           state_s = ST_CLEAR;
         end
         default: state_s = ST_PWR_WAIT;
      endcase
   end

   // Byte offered to the writer and next handshake outputs
   always_comb begin
      tx_s = init_byte(4'd0);
      case (state_r)
         ST_PWR_WAIT: tx_s = init_byte(4'd0);
         ST_INIT:     tx_s = init_byte(idx_r + 4'd1);
         ST_CONVERT:  tx_s = line_byte(4'd0, reg_r, neg_r, bcd_r);
         ST_WRITE:    tx_s = line_byte(idx_r + 4'd1, reg_r, neg_r, bcd_r);
         default:     tx_s = {1'b0, CMD_CLEAR};
      endcase
      wr_long_s = !tx_s.rs && (tx_s.data == CMD_CLEAR);
      ready_s   = (state_s == ST_IDLE) || (state_s == ST_DONE);
      done_s    = (state_s == ST_DONE);
   end

   // State, counters, request latch and BCD converter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= ST_PWR_WAIT;
         pwr_cnt_r  <= '0;
         idx_r      <= 4'd0;
         conv_cnt_r <= 4'd0;
         reg_r      <= 4'd0;
         neg_r      <= 1'b0;
         bin_r      <= 16'd0;
         bcd_r      <= 20'd0;
         ready_r    <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= ready_s;
         done_r  <= done_s;
         if (state_r == ST_PWR_WAIT) pwr_cnt_r <= pwr_cnt_r + CNT_W'(1);
         else                        pwr_cnt_r <= '0;
         if (start_s && ((state_r == ST_INIT) || (state_r == ST_WRITE))) idx_r <= idx_r + 4'd1;
         else if (start_s)                                            idx_r <= 4'd0;
         else                                                         idx_r <= idx_r;
         if (accept_s && !bus.disp_clr) begin
            reg_r      <= bus.disp_reg;
            neg_r      <= bus.disp_value[15];
            bin_r      <= mag_s;
            bcd_r      <= 20'd0;
            conv_cnt_r <= 4'd0;
         end else if (state_r == ST_CONVERT) begin
            bcd_r      <= (bcd_adj_s << 1) | {19'd0, bin_r[15]};
            bin_r      <= bin_r << 1;
            conv_cnt_r <= conv_cnt_r + 4'd1;
         end else begin
            bcd_r <= bcd_r;
         end
      end
   end

   lcd_byte_writer #(
      .T_SETUP (T_SETUP),
      .T_PULSE (T_PULSE),
      .T_CMD   (T_CMD),
      .T_CLEAR (T_CLEAR),
      .CNT_W   (CNT_W)
   ) u_writer (
      .clk          (clk),
      .reset        (reset),
      .start        (wr_go_s),
      .byte_val     (tx_s.data),
      .rs           (tx_s.rs),
      .long_wait    (wr_long_s),
      .lcd_data_bus (lcd_data_bus),
      .lcd_rs       (lcd_rs),
      .lcd_e        (lcd_e),
      .busy         (wr_busy_s),
      .byte_done    (wr_done_s)
   );

   assign bus.disp_ready = ready_r;
   assign bus.disp_done  = done_r;
   assign lcd_rw         = 1'b0;

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Self-checking bench for lcd_display_ctrl: LCD bytes captured on E fall are
// compared against text formatted straight from the display rules.
module tb_lcd_display_ctrl;

   localparam int T_POWER    = 10;
   localparam int T_SETUP    = 1;
   localparam int T_PULSE    = 2;
   localparam int T_CMD      = 3;
   localparam int T_CLEAR    = 6;
   localparam int T_BYTE     = T_SETUP + T_PULSE + T_CMD;
   localparam int T_BYTE_CLR = T_SETUP + T_PULSE + T_CLEAR;
   localparam int INIT_READY = T_POWER + 3 * T_BYTE + T_BYTE_CLR;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] lcd_data_bus;
   logic       lcd_rs, lcd_rw, lcd_e;

   lcd_display_ctrl_if bus_if();

   lcd_display_ctrl #(
      .T_POWER (T_POWER), .T_SETUP (T_SETUP), .T_PULSE (T_PULSE),
      .T_CMD   (T_CMD),   .T_CLEAR (T_CLEAR), .CNT_W   (20)
   ) dut (
      .clk (clk), .reset (reset), .bus (bus_if),
      .lcd_data_bus (lcd_data_bus), .lcd_rs (lcd_rs), .lcd_rw (lcd_rw), .lcd_e (lcd_e)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pin-level monitor: byte capture on E fall, pulse width, setup and hold
   logic [8:0] prev_byte = 9'h000;
   logic       e_prev = 1'b0;
   int         hi_cnt = 0, since_fall = 1000, since_chg = 1000, wait_need = T_CMD;

   always @(negedge clk) begin
      if (!reset) begin
         e_prev     <= 1'b0;
         hi_cnt     <= 0;
         since_fall <= 1000;
         since_chg  <= 1000;
         prev_byte  <= {lcd_rs, lcd_data_bus};
      end else begin
         prev_byte  <= {lcd_rs, lcd_data_bus};
         since_chg  <= ({lcd_rs, lcd_data_bus} !== prev_byte) ? 1 : since_chg + 1;
         since_fall <= (e_prev && !lcd_e) ? 1 : since_fall + 1;
         hi_cnt     <= lcd_e ? hi_cnt + 1 : 0;
         e_prev     <= lcd_e;
         if ({lcd_rs, lcd_data_bus} !== prev_byte)
            chk("data_hold_through_wait", 32'(since_fall >= wait_need), 32'd1);
         if (lcd_e && !e_prev)
            chk("data_setup_before_e", 32'((since_chg >= T_SETUP) && ({lcd_rs, lcd_data_bus} === prev_byte)), 32'd1);
         if (!lcd_e && e_prev) begin
            chk("e_pulse_width", 32'(hi_cnt), 32'(T_PULSE));
            chk("lcd_rw_low", 32'(lcd_rw), 32'd0);
            got_q.push_back({lcd_rs, lcd_data_bus});
            wait_need <= ({lcd_rs, lcd_data_bus} == 9'h001) ? T_CLEAR : T_CMD;
         end
      end
   end

   task automatic build_expected(input logic req, input logic clr, input logic [3:0] r,
                                 input logic signed [15:0] v);
      string s;
      int    iv, mag;
      exp_q.delete();
      if (clr) begin
         exp_q.push_back(9'h001);
      end else if (req) begin
         iv  = int'(v);
         mag = (iv < 0) ? -iv : iv;
         s   = $sformatf("R%02d = %s%05d", int'(r), (iv < 0) ? "-" : "+", mag);
         exp_q.push_back(9'h080);
         for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, 8'(s[i])});
      end
   endtask

   task automatic compare_bytes(input string tag);
      chk({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      bit ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         n++;
         if (bus_if.disp_ready) ok = 1'b1;
      end
      chk({tag, "_ready_seen"}, 32'(ok), 32'd1);
      chk({tag, "_ready_cycle"}, 32'(n), 32'(INIT_READY));
   endtask

   // One request issued at a negedge; poke_at >= 1 pulses a stray request while busy
   task automatic request(input logic req, input logic clr, input logic [3:0] r,
                          input logic signed [15:0] v, input int poke_at, input string tag);
      int start_cyc, rel, exp_done;
      bit seen = 1'b0;
      build_expected(req, clr, r, v);
      exp_done = clr ? 1 + T_BYTE_CLR : 1 + 16 + 13 * T_BYTE;
      got_q.delete();
      bus_if.disp_req   = req;
      bus_if.disp_clr   = clr;
      bus_if.disp_reg   = r;
      bus_if.disp_value = v;
      start_cyc = cyc + 1;
      @(negedge clk);
      bus_if.disp_req = 1'b0;
      bus_if.disp_clr = 1'b0;
      chk({tag, "_not_ready_cycle1"}, 32'(bus_if.disp_ready), 32'd0);
      for (int k = 0; k < 400 && !seen; k++) begin
         rel = cyc - start_cyc + 1;
         if (rel == poke_at) begin
            bus_if.disp_req   = 1'b1;
            bus_if.disp_clr   = 1'b1;
            bus_if.disp_reg   = ~r;
            bus_if.disp_value = ~v;
         end else begin
            bus_if.disp_req = 1'b0;
            bus_if.disp_clr = 1'b0;
         end
         if (bus_if.disp_done) begin
            seen = 1'b1;
            chk({tag, "_done_cycle"}, 32'(rel), 32'(exp_done));
            chk({tag, "_ready_with_done"}, 32'(bus_if.disp_ready), 32'd1);
         end else begin
            @(negedge clk);
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      compare_bytes(tag);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(bus_if.disp_done), 32'd0);
   endtask

   task automatic expect_init();
      exp_q.delete();
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h006);
      exp_q.push_back(9'h001);
   endtask

   initial begin
      bit reached = 1'b0;
      logic [3:0] rr;
      logic signed [15:0] rv;
      logic rc;

      bus_if.disp_req   = 1'b0;
      bus_if.disp_clr   = 1'b0;
      bus_if.disp_reg   = 4'd0;
      bus_if.disp_value = 16'sd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus_if.disp_ready), 32'd0);
      chk("rst_done",  32'(bus_if.disp_done),  32'd0);
      chk("rst_e",     32'(lcd_e),             32'd0);
      chk("rst_pins",  32'({lcd_rs, lcd_data_bus}), 32'd0);

      got_q.delete();
      reset = 1'b1;
      expect_init();
      wait_ready("init");
      compare_bytes("init");

      request(1'b1, 1'b0, 4'd15, 16'sh8000, -1, "r15_min");
      request(1'b1, 1'b0, 4'd0,  16'sd1234, -1, "r0_1234");
      request(1'b1, 1'b0, 4'd0,  16'sd0,    -1, "r0_zero");
      request(1'b1, 1'b1, 4'd7,  16'sd555,  -1, "req_and_clr");
      request(1'b0, 1'b1, 4'd2,  16'sd9,     5, "clr_poke");
      request(1'b1, 1'b0, 4'd9,  16'sd32767, 40, "busy_poke");

      for (int n = 0; n < 8; n++) begin
         rr = 4'($urandom_range(0, 15));
         rv = 16'($urandom);
         rc = ($urandom_range(0, 3) == 0);
         request(!rc, rc, rr, rv, int'($urandom_range(2, 60)), $sformatf("rand%0d", n));
      end

      // Reset in the middle of a character write
      got_q.delete();
      bus_if.disp_req   = 1'b1;
      bus_if.disp_reg   = 4'd3;
      bus_if.disp_value = 16'sd77;
      @(negedge clk);
      bus_if.disp_req = 1'b0;
      for (int k = 0; k < 300 && !reached; k++) begin
         @(negedge clk);
         if ((got_q.size() >= 3) && lcd_e) reached = 1'b1;
      end
      chk("midchar_reached", 32'(reached), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_e_low", 32'(lcd_e),             32'd0);
      chk("midrst_pins",  32'({lcd_rs, lcd_data_bus}), 32'd0);
      chk("midrst_ready", 32'(bus_if.disp_ready), 32'd0);
      @(negedge clk);
      got_q.delete();
      reset = 1'b1;
      expect_init();
      wait_ready("reinit");
      compare_bytes("reinit");
      request(1'b1, 1'b0, 4'd11, -16'sd42, -1, "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
